// File: rtl/riscv_pkg.sv
// Shared RV32I load/store encodings and data-memory responder state encodings.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } resp_state_e;

endpackage

// File: rtl/d_mem_responder_if.sv
// EX/MEM-to-data-memory request/response bundle.
interface d_mem_responder_if;
    logic        read;
    logic        write;
    logic [2:0]  fun_3;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        busywait;

    modport master (
        output read, write, fun_3, address, writedata,
        input  readdata, busywait
    );

    modport slave (
        input  read, write, fun_3, address, writedata,
        output readdata, busywait
    );
endinterface

// File: rtl/d_mem_responder_ls_align.sv
// RV32I byte-lane logic: load extraction/extension and store merge into an old word.
module ls_align
    import riscv_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] writedata,
    input  logic [2:0]  fun_3,
    input  logic [1:0]  byte_off,
    output logic [31:0] load_data,
    output logic [31:0] store_word,
    output logic        store_ok
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [3:0]  byte_en;
    logic [31:0] store_lanes;

    always_comb begin
        lane_byte = word[7:0];
        case (byte_off)
            2'd1:    lane_byte = word[15:8];
            2'd2:    lane_byte = word[23:16];
            2'd3:    lane_byte = word[31:24];
            default: lane_byte = word[7:0];
        endcase
        lane_half = byte_off[1] ? word[31:16] : word[15:0];

        case (fun_3)
            F3_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
            F3_LH:   load_data = {{16{lane_half[15]}}, lane_half};
            F3_LW:   load_data = word;
            F3_LBU:  load_data = {24'd0, lane_byte};
            F3_LHU:  load_data = {16'd0, lane_half};
            default: load_data = 32'd0;
        endcase
    end

    // Store data is replicated across lanes so each lane only needs a byte enable.
    always_comb begin
        byte_en     = 4'b0000;
        store_lanes = writedata;
        case (fun_3)
            F3_SB: begin
                byte_en     = 4'b0001 << byte_off;
                store_lanes = {4{writedata[7:0]}};
            end
            F3_SH: begin
                byte_en     = byte_off[1] ? 4'b1100 : 4'b0011;
                store_lanes = {2{writedata[15:0]}};
            end
            F3_SW: begin
                byte_en     = 4'b1111;
                store_lanes = writedata;
            end
            default: ;
        endcase
    end

    assign store_ok = |byte_en;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign store_word[8*gi +: 8] = byte_en[gi] ? store_lanes[8*gi +: 8]
                                                       : word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/d_mem_responder.sv
// Fixed-latency RV32I data memory: stalls the pipeline via busywait and performs
// the access (array write or readdata update) on the last busy cycle.
module d_mem_responder
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input logic              clk,
    input logic              reset,
    d_mem_responder_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] WAIT = ST_WAIT;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]       state_reg;
    logic [3:0]       cnt_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [1:0]       off_reg;
    logic [2:0]       fun3_reg;
    logic [31:0]      wdata_reg;
    logic             read_reg;
    logic             write_reg;
    logic [31:0]      rword_reg;
    logic [31:0]      readdata_reg;

    logic [31:0]      mem [DEPTH_WORDS];

    logic             req;
    logic             finish;
    logic             mem_we;
    logic [IDX_W-1:0] req_idx;
    logic [31:0]      load_data;
    logic [31:0]      store_word;
    logic             store_ok;

    assign req     = bus.read | bus.write;
    assign req_idx = bus.address[IDX_W+1:2];
    assign finish  = (state_reg == WAIT) && (cnt_reg == 4'd0);
    // Array is touched only at completion, so a reset mid-access drops the store.
    assign mem_we  = finish && write_reg && !read_reg && store_ok && !reset;

    ls_align u_align (
        .word       (rword_reg),
        .writedata  (wdata_reg),
        .fun_3      (fun3_reg),
        .byte_off   (off_reg),
        .load_data  (load_data),
        .store_word (store_word),
        .store_ok   (store_ok)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            idx_reg      <= '0;
            off_reg      <= 2'd0;
            fun3_reg     <= 3'd0;
            wdata_reg    <= 32'd0;
            read_reg     <= 1'b0;
            write_reg    <= 1'b0;
            readdata_reg <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        idx_reg   <= req_idx;
                        off_reg   <= bus.address[1:0];
                        fun3_reg  <= bus.fun_3;
                        wdata_reg <= bus.writedata;
                        read_reg  <= bus.read;
                        write_reg <= bus.write;
                        cnt_reg   <= 4'(LATENCY - 1);
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        if (read_reg && write_reg) begin
                            readdata_reg <= 32'd0;
                        end else if (read_reg) begin
                            readdata_reg <= load_data;
                        end
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Block RAM port: old word fetched when the request is accepted, written at completion.
    always_ff @(posedge clk) begin
        if ((state_reg == IDLE) && req) begin
            rword_reg <= mem[req_idx];
        end
        if (mem_we) begin
            mem[idx_reg] <= store_word;
        end
    end

    always_comb begin
        case (state_reg)
            IDLE:    bus.busywait = req;
            WAIT:    bus.busywait = 1'b1;
            default: bus.busywait = 1'b0;
        endcase
    end

    assign bus.readdata = readdata_reg;

endmodule
